// File: rtl/vga_pkg.sv
// Shared pixel definitions for the VGA pixel path.
// Pixels are stored as {r,g,b} with red in the top bit.
package vga_pkg;
  localparam int PIX_W = 3;
  localparam int R_BIT = 2;
  localparam int G_BIT = 1;
  localparam int B_BIT = 0;
  localparam logic [PIX_W-1:0] BLACK_PIXEL = 3'b000;
endpackage

// File: rtl/vga_fifo_mem.sv
// Register-file storage for the pixel FIFO.
// Synchronous write and asynchronous read, so it maps to LUT RAM.
module vga_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int PIX_W = 3,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel prefetch FIFO in front of vga_driver.
// Registered pixel output with sticky and counted underflow status.
module vga_pixel_fifo #(
  parameter int DEPTH   = 16,
  parameter int PIX_W   = 3,
  parameter int UFLOW_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic               clk_50Mhz,
  input  logic               reset_,
  input  logic               i_flush,
  input  logic               i_clr_stat,
  input  logic               i_wr_valid,
  input  logic [PIX_W-1:0]   i_wr_pixel,
  output logic               o_wr_ready,
  input  logic               i_fetch,
  output logic               o_pixel_r,
  output logic               o_pixel_g,
  output logic               o_pixel_b,
  output logic [LW-1:0]      o_level,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_underflow,
  output logic [UFLOW_W-1:0] o_uflow_cnt
);

  import vga_pkg::*;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [UFLOW_W-1:0] CNT_ONE = 1;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      level;
  logic [PIX_W-1:0]   pix;
  logic [PIX_W-1:0]   head;
  logic               uflow_q;
  logic [UFLOW_W-1:0] cnt_q;
  logic               empty;
  logic               full;
  logic               push_acc;
  logic               pop_acc;
  logic               uflow;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

  // Flush swallows both sides of the handshake for that cycle.
  assign push_acc = i_wr_valid && !full && !i_flush;
  assign pop_acc  = i_fetch && !empty && !i_flush;
  assign uflow    = i_fetch && empty && !i_flush;

  vga_fifo_mem #(
    .DEPTH(DEPTH),
    .PIX_W(PIX_W)
  ) u_mem (
    .clk   (clk_50Mhz),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (i_wr_pixel),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk_50Mhz or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      pix    <= BLACK_PIXEL;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      pix    <= BLACK_PIXEL;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
        pix    <= head;
      end else if (uflow) begin
        pix    <= BLACK_PIXEL;
      end
      level <= level + LW'(push_acc) - LW'(pop_acc);
    end
  end

  always_ff @(posedge clk_50Mhz or negedge reset_) begin
    if (!reset_) begin
      uflow_q <= 1'b0;
      cnt_q   <= '0;
    end else if (i_clr_stat) begin
      uflow_q <= 1'b0;
      cnt_q   <= '0;
    end else if (uflow) begin
      uflow_q <= 1'b1;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign o_wr_ready  = !full;
  assign o_level     = level;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_underflow = uflow_q;
  assign o_uflow_cnt = cnt_q;
  assign o_pixel_r   = pix[R_BIT];
  assign o_pixel_g   = pix[G_BIT];
  assign o_pixel_b   = pix[B_BIT];

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Self-checking bench for vga_pixel_fifo.
// Table-driven vectors plus directed multi-cycle sequences.
module tb_vga_pixel_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, clr, wv, fetch;
  logic [2:0] wpix;
  logic       ready, pr, pg, pb, empty, full, uf;
  logic [4:0] level;
  logic [7:0] cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_pixel_fifo dut (
    .clk_50Mhz   (clk),
    .reset_      (rst_n),
    .i_flush     (flush),
    .i_clr_stat  (clr),
    .i_wr_valid  (wv),
    .i_wr_pixel  (wpix),
    .o_wr_ready  (ready),
    .i_fetch     (fetch),
    .o_pixel_r   (pr),
    .o_pixel_g   (pg),
    .o_pixel_b   (pb),
    .o_level     (level),
    .o_empty     (empty),
    .o_full      (full),
    .o_underflow (uf),
    .o_uflow_cnt (cnt)
  );

  typedef struct {
    logic       wv;
    logic [2:0] wpix;
    logic       fetch;
    logic       clr;
    int         lvl;
    int         pix;
    int         emp;
    int         uf;
    int         cnt;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wv = 0; fetch = 0; flush = 0; clr = 0; wpix = 3'b000;
  endtask

  function automatic int pixv();
    return int'({pr, pg, pb});
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    vt[0]  = '{1, 3'b100, 0, 0, 1, 0, 0, 0, 0};
    vt[1]  = '{1, 3'b010, 0, 0, 2, 0, 0, 0, 0};
    vt[2]  = '{1, 3'b001, 0, 0, 3, 0, 0, 0, 0};
    vt[3]  = '{0, 3'b000, 1, 0, 2, 4, 0, 0, 0};
    vt[4]  = '{0, 3'b000, 1, 0, 1, 2, 0, 0, 0};
    vt[5]  = '{0, 3'b000, 1, 0, 0, 1, 1, 0, 0};
    vt[6]  = '{0, 3'b000, 0, 0, 0, 1, 1, 0, 0};
    vt[7]  = '{0, 3'b000, 1, 0, 0, 0, 1, 1, 1};
    vt[8]  = '{1, 3'b110, 1, 0, 1, 0, 0, 1, 2};
    vt[9]  = '{0, 3'b000, 1, 0, 0, 6, 1, 1, 2};
    vt[10] = '{1, 3'b011, 0, 0, 1, 6, 0, 1, 2};
    vt[11] = '{1, 3'b101, 1, 0, 1, 3, 0, 1, 2};
    vt[12] = '{0, 3'b000, 1, 1, 0, 5, 1, 0, 0};
    vt[13] = '{0, 3'b000, 1, 1, 0, 0, 1, 0, 0};

    #12;
    chk("reset_level", int'(level), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_ready", int'(ready), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_pixel", pixv(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vt[i]) begin
      wv = vt[i].wv; wpix = vt[i].wpix;
      fetch = vt[i].fetch; clr = vt[i].clr;
      step();
      chk($sformatf("v%0d_level", i), int'(level), vt[i].lvl);
      chk($sformatf("v%0d_pixel", i), pixv(), vt[i].pix);
      chk($sformatf("v%0d_empty", i), int'(empty), vt[i].emp);
      chk($sformatf("v%0d_uflow", i), int'(uf), vt[i].uf);
      chk($sformatf("v%0d_cnt", i), int'(cnt), vt[i].cnt);
    end
    idle();

    // Full back-pressure: 16 pushes fill, the 17th waits.
    wv = 1;
    for (int i = 0; i < 16; i++) begin
      wpix = 3'((i + 1) % 8);
      step();
    end
    chk("full_level", int'(level), 16);
    chk("full_flag", int'(full), 1);
    chk("full_ready", int'(ready), 0);
    wpix = 3'b111;
    step();
    chk("full_hold_level", int'(level), 16);
    fetch = 1;
    step();
    chk("full_pop_level", int'(level), 15);
    chk("full_pop_pixel", pixv(), 1);
    chk("full_pop_ready", int'(ready), 1);
    fetch = 0;
    step();
    chk("full_accept17", int'(level), 16);
    wv = 0;
    for (int i = 0; i < 16; i++) begin
      fetch = 1;
      step();
    end
    fetch = 0;
    chk("drain_last_pixel", pixv(), 7);
    chk("drain_empty", int'(empty), 1);
    chk("drain_uflow_cnt", int'(cnt), 0);

    // Saturating underflow counter.
    fetch = 1;
    for (int i = 0; i < 3; i++) step();
    chk("uf3_cnt", int'(cnt), 3);
    chk("uf3_flag", int'(uf), 1);
    chk("uf3_pixel", pixv(), 0);
    for (int i = 0; i < 297; i++) step();
    chk("uf_sat_cnt", int'(cnt), 255);
    fetch = 0;
    clr = 1;
    step();
    clr = 0;
    chk("clr_cnt", int'(cnt), 0);
    chk("clr_flag", int'(uf), 0);

    // Flush priority over push and fetch.
    wv = 1; wpix = 3'b111;
    for (int i = 0; i < 5; i++) step();
    wv = 0; fetch = 1;
    step();
    wv = 1; fetch = 0;
    step();
    wv = 0;
    chk("pre_flush_level", int'(level), 5);
    chk("pre_flush_pixel", pixv(), 7);
    flush = 1; wv = 1; fetch = 1;
    step();
    idle();
    chk("flush_level", int'(level), 0);
    chk("flush_pixel", pixv(), 0);
    chk("flush_cnt", int'(cnt), 0);
    chk("flush_uflow", int'(uf), 0);
    fetch = 1;
    step();
    fetch = 0;
    chk("flush_push_dropped", int'(cnt), 1);

    // Asynchronous reset mid-traffic.
    wv = 1; wpix = 3'b110;
    step();
    step();
    wv = 0; fetch = 1;
    step();
    fetch = 0; wv = 1;
    chk("pre_rst_level", int'(level), 1);
    chk("pre_rst_pixel", pixv(), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_pixel", pixv(), 0);
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_ready", int'(ready), 1);
    chk("async_rst_uflow", int'(uf), 0);
    chk("async_rst_cnt", int'(cnt), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
